// File: rtl/color_calib_pkg.sv
// Shared types and constants for the colour calibration sequencer.
// Optional min/max tracking is enabled with COLOR_CALIB_MINMAX_EN.
package color_calib_pkg;

  localparam int unsigned WIN_HALF = 8;
  localparam int unsigned WIN_PIX  = 256;
  localparam int unsigned SUM_W    = 18;
  localparam int unsigned CHAN_W   = 10;

  typedef logic [CHAN_W-1:0] chan_t;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StAccum,
    StDone,
    StFail
  } calib_state_t;

  // Mean of exactly WIN_PIX samples: truncating divide by 256.
  function automatic chan_t sum_to_mean(input logic [SUM_W-1:0] s);
    return CHAN_W'(s >> (SUM_W - CHAN_W));
  endfunction

endpackage

// File: rtl/chan_accum.sv
// One colour channel of the window accumulator: running sum, plus optional
// min/max trackers when COLOR_CALIB_MINMAX_EN is defined.
module chan_accum
  import color_calib_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  chan_t            din,
`ifdef COLOR_CALIB_MINMAX_EN
  output chan_t            min_val,
  output chan_t            max_val,
`endif
  output logic [SUM_W-1:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + {{(SUM_W - CHAN_W){1'b0}}, din};
    end
  end

`ifdef COLOR_CALIB_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= '1;
      max_val <= '0;
    end else if (clr) begin
      min_val <= '1;
      max_val <= '0;
    end else if (en) begin
      if (din < min_val) min_val <= din;
      if (din > max_val) max_val <= din;
    end
  end
`endif

endmodule

// File: rtl/color_calib_ctrl.sv
// Calibration sequencer: averages a 16x16 window around (CX, CY) over one frame
// and publishes the reference colour. COLOR_CALIB_MINMAX_EN adds min/max outputs.
module color_calib_ctrl
  import color_calib_pkg::*;
#(
  parameter int unsigned CX = 640,
  parameter int unsigned CY = 512
) (
  input  logic        CLK,
  input  logic        Reset_N,
  input  logic [9:0]  Rin,
  input  logic [9:0]  Gin,
  input  logic [9:0]  Bin,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic        pixel_en,
  input  logic        VGA_VS,
  input  logic        calib_req,
  output logic        busy,
  output logic        cal_done,
  output logic        cal_err,
  output logic        run,
`ifdef COLOR_CALIB_MINMAX_EN
  output logic [9:0]  min_r,
  output logic [9:0]  min_g,
  output logic [9:0]  min_b,
  output logic [9:0]  max_r,
  output logic [9:0]  max_g,
  output logic [9:0]  max_b,
`endif
  output logic [9:0]  ref_r,
  output logic [9:0]  ref_g,
  output logic [9:0]  ref_b
);

  if (CX < WIN_HALF || CY < WIN_HALF) begin : g_bad_centre
    $error("color_calib_ctrl: CX and CY must be at least %0d", WIN_HALF);
  end

  localparam logic [10:0] XLo = 11'(CX - WIN_HALF);
  localparam logic [10:0] XHi = 11'(CX + WIN_HALF - 1);
  localparam logic [10:0] YLo = 11'(CY - WIN_HALF);
  localparam logic [10:0] YHi = 11'(CY + WIN_HALF - 1);

  calib_state_t state_q, state_d;
  logic         vs_q;
  logic [8:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         run_q, run_d;
  logic         run_save_q, run_save_d;
  chan_t        ref_r_q, ref_g_q, ref_b_q;
  logic         load_ref, acc_clr, acc_en;
  logic         vs_fall, in_win, pix_hit;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;

  assign vs_fall = vs_q & ~VGA_VS;
  assign in_win  = (X >= XLo) && (X <= XHi) && (Y >= YLo) && (Y <= YHi);
  assign pix_hit = pixel_en & in_win;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    run_d      = run_q;
    run_save_d = run_save_q;
    load_ref   = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (calib_req) begin
          state_d    = StArm;
          busy_d     = 1'b1;
          run_save_d = run_q;
          run_d      = 1'b0;
        end
      end
      StArm: begin
        if (vs_fall) begin
          state_d = StAccum;
          acc_clr = 1'b1;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (pix_hit) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + 9'd1;
        end
        // A full window on the same edge as the next frame start still counts.
        if (pix_hit && cnt_q == 9'(WIN_PIX - 1)) begin
          state_d = StDone;
        end else if (vs_fall) begin
          state_d = StFail;
        end
      end
      StDone: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        err_d    = 1'b0;
        run_d    = 1'b1;
        load_ref = 1'b1;
      end
      StFail: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        run_d   = run_save_q;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef COLOR_CALIB_MINMAX_EN
  chan_t cmin_r, cmin_g, cmin_b, cmax_r, cmax_g, cmax_b;
  chan_t min_r_q, min_g_q, min_b_q, max_r_q, max_g_q, max_b_q;
`endif

  chan_accum u_acc_r (
    .clk     (CLK),
    .rst_n   (Reset_N),
    .clr     (acc_clr),
    .en      (acc_en),
    .din     (Rin),
`ifdef COLOR_CALIB_MINMAX_EN
    .min_val (cmin_r),
    .max_val (cmax_r),
`endif
    .sum     (sum_r)
  );

  chan_accum u_acc_g (
    .clk     (CLK),
    .rst_n   (Reset_N),
    .clr     (acc_clr),
    .en      (acc_en),
    .din     (Gin),
`ifdef COLOR_CALIB_MINMAX_EN
    .min_val (cmin_g),
    .max_val (cmax_g),
`endif
    .sum     (sum_g)
  );

  chan_accum u_acc_b (
    .clk     (CLK),
    .rst_n   (Reset_N),
    .clr     (acc_clr),
    .en      (acc_en),
    .din     (Bin),
`ifdef COLOR_CALIB_MINMAX_EN
    .min_val (cmin_b),
    .max_val (cmax_b),
`endif
    .sum     (sum_b)
  );

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= StIdle;
      vs_q       <= 1'b1;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
      run_save_q <= 1'b0;
      ref_r_q    <= '0;
      ref_g_q    <= '0;
      ref_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= VGA_VS;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      run_q      <= run_d;
      run_save_q <= run_save_d;
      if (load_ref) begin
        ref_r_q <= sum_to_mean(sum_r);
        ref_g_q <= sum_to_mean(sum_g);
        ref_b_q <= sum_to_mean(sum_b);
      end
    end
  end

`ifdef COLOR_CALIB_MINMAX_EN
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      min_r_q <= '0;
      min_g_q <= '0;
      min_b_q <= '0;
      max_r_q <= '0;
      max_g_q <= '0;
      max_b_q <= '0;
    end else if (load_ref) begin
      min_r_q <= cmin_r;
      min_g_q <= cmin_g;
      min_b_q <= cmin_b;
      max_r_q <= cmax_r;
      max_g_q <= cmax_g;
      max_b_q <= cmax_b;
    end
  end

  assign min_r = min_r_q;
  assign min_g = min_g_q;
  assign min_b = min_b_q;
  assign max_r = max_r_q;
  assign max_g = max_g_q;
  assign max_b = max_b_q;
`endif

  assign busy     = busy_q;
  assign cal_done = done_q;
  assign cal_err  = err_q;
  assign run      = run_q;
  assign ref_r    = ref_r_q;
  assign ref_g    = ref_g_q;
  assign ref_b    = ref_b_q;

endmodule

// File: tb/tb_color_calib_ctrl.sv
// Randomised bench for color_calib_ctrl against a frame-level reference model.
// Min/max checks are compiled in when COLOR_CALIB_MINMAX_EN is defined.
module tb_color_calib_ctrl;

  localparam int CX = 640;
  localparam int CY = 512;

  logic        CLK = 1'b0;
  logic        Reset_N = 1'b0;
  logic [9:0]  Rin, Gin, Bin;
  logic [10:0] X, Y;
  logic        pixel_en, VGA_VS, calib_req;
  logic        busy, cal_done, cal_err, run;
  logic [9:0]  ref_r, ref_g, ref_b;
`ifdef COLOR_CALIB_MINMAX_EN
  logic [9:0]  min_r, min_g, min_b, max_r, max_g, max_b;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit check_en = 1'b0;

  always #5 CLK = ~CLK;

  color_calib_ctrl #(.CX(CX), .CY(CY)) dut (
    .CLK       (CLK),
    .Reset_N   (Reset_N),
    .Rin       (Rin),
    .Gin       (Gin),
    .Bin       (Bin),
    .X         (X),
    .Y         (Y),
    .pixel_en  (pixel_en),
    .VGA_VS    (VGA_VS),
    .calib_req (calib_req),
    .busy      (busy),
    .cal_done  (cal_done),
    .cal_err   (cal_err),
    .run       (run),
`ifdef COLOR_CALIB_MINMAX_EN
    .min_r     (min_r),
    .min_g     (min_g),
    .min_b     (min_b),
    .max_r     (max_r),
    .max_g     (max_g),
    .max_b     (max_b),
`endif
    .ref_r     (ref_r),
    .ref_g     (ref_g),
    .ref_b     (ref_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input int x, input int y);
    return x >= CX - 8 && x <= CX + 7 && y >= CY - 8 && y <= CY + 7;
  endfunction

  // Reference model: tracks the calibration as a sequence of phases and
  // computes the reference as the integer mean of the collected samples.
  bit m_busy, m_done, m_err, m_run, m_run_before;
  bit m_vs_prev = 1'b1;
  bit m_armed, m_collect, m_fin_ok, m_fin_bad;
  bit vs_fall;
  int m_n;
  int m_sum[3];
  int m_ref[3];
  int px[3];
  int m_min[3], m_max[3], m_lmin[3], m_lmax[3];

  always @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      m_busy = 0; m_done = 0; m_err = 0; m_run = 0; m_run_before = 0;
      m_vs_prev = 1; m_armed = 0; m_collect = 0; m_fin_ok = 0; m_fin_bad = 0;
      m_n = 0;
      for (int c = 0; c < 3; c++) begin
        m_sum[c] = 0; m_ref[c] = 0; m_lmin[c] = 0; m_lmax[c] = 0;
      end
    end else begin
      vs_fall = m_vs_prev && !VGA_VS;
      m_vs_prev = VGA_VS;
      m_done = 0;
      px[0] = int'(Rin); px[1] = int'(Gin); px[2] = int'(Bin);
      if (m_fin_ok) begin
        for (int c = 0; c < 3; c++) begin
          m_ref[c] = m_sum[c] / 256;
          m_lmin[c] = m_min[c];
          m_lmax[c] = m_max[c];
        end
        m_done = 1; m_run = 1; m_err = 0; m_busy = 0; m_fin_ok = 0;
      end else if (m_fin_bad) begin
        m_err = 1; m_run = m_run_before; m_busy = 0; m_fin_bad = 0;
      end else if (m_collect) begin
        if (pixel_en && in_window(int'(X), int'(Y))) begin
          for (int c = 0; c < 3; c++) begin
            m_sum[c] += px[c];
            if (px[c] < m_min[c]) m_min[c] = px[c];
            if (px[c] > m_max[c]) m_max[c] = px[c];
          end
          m_n++;
        end
        if (m_n == 256) begin
          m_collect = 0; m_fin_ok = 1;
        end else if (vs_fall) begin
          m_collect = 0; m_fin_bad = 1;
        end
      end else if (m_armed) begin
        if (vs_fall) begin
          m_armed = 0; m_collect = 1; m_n = 0;
          for (int c = 0; c < 3; c++) begin
            m_sum[c] = 0; m_min[c] = 1023; m_max[c] = 0;
          end
        end
      end else if (calib_req) begin
        m_armed = 1; m_busy = 1; m_run_before = m_run; m_run = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (cal_done) done_cnt++;
    if (check_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("cal_done", int'(cal_done), int'(m_done));
      chk("cal_err", int'(cal_err), int'(m_err));
      chk("run", int'(run), int'(m_run));
      chk("ref_r", int'(ref_r), m_ref[0]);
      chk("ref_g", int'(ref_g), m_ref[1]);
      chk("ref_b", int'(ref_b), m_ref[2]);
`ifdef COLOR_CALIB_MINMAX_EN
      chk("min_r", int'(min_r), m_lmin[0]);
      chk("min_g", int'(min_g), m_lmin[1]);
      chk("min_b", int'(min_b), m_lmin[2]);
      chk("max_r", int'(max_r), m_lmax[0]);
      chk("max_g", int'(max_g), m_lmax[1]);
      chk("max_b", int'(max_b), m_lmax[2]);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      pixel_en = 1'b0;
    end
  endtask

  task automatic vs_pulse();
    @(negedge CLK);
    pixel_en = 1'b0;
    VGA_VS = 1'b0;
    repeat (2) @(negedge CLK);
    VGA_VS = 1'b1;
  endtask

  task automatic req_pulse();
    @(negedge CLK);
    calib_req = 1'b1;
    @(negedge CLK);
    calib_req = 1'b0;
  endtask

  // Frame start then a 20x20 scan around the centre; at most max_win window pixels
  // are qualified. Random idle cycles carry junk in-window data with pixel_en low.
  task automatic frame(input int mode, input int max_win);
    int nw;
    bit win;
    nw = 0;
    vs_pulse();
    for (int y = CY - 10; y < CY + 10; y++) begin
      for (int x = CX - 10; x < CX + 10; x++) begin
        win = in_window(x, y);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge CLK);
          pixel_en = 1'b0;
          X = 11'(CX); Y = 11'(CY);
          Rin = 10'($urandom); Gin = 10'($urandom); Bin = 10'($urandom);
        end
        @(negedge CLK);
        X = 11'(x); Y = 11'(y);
        pixel_en = !(win && nw >= max_win);
        case (mode)
          0: begin Rin = 10'd300; Gin = 10'd500; Bin = 10'd100; end
          1: begin
            if (win) begin Rin = 10'((x - (CX - 8)) * 4); Gin = '0; Bin = '0; end
            else begin Rin = 10'd1023; Gin = 10'd1023; Bin = 10'd1023; end
          end
          3: begin
            Rin = 10'($urandom); Bin = 10'($urandom);
            if (win) Gin = (nw == 0) ? 10'd10 : (nw == 1) ? 10'd900 : 10'($urandom_range(10, 900));
            else Gin = ($urandom_range(0, 1) != 0) ? 10'd1023 : 10'd0;
          end
          default: begin Rin = 10'($urandom); Gin = 10'($urandom); Bin = 10'($urandom); end
        endcase
        if (win && pixel_en) nw++;
      end
    end
    @(negedge CLK);
    pixel_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    VGA_VS = 1'b1; pixel_en = 1'b0; calib_req = 1'b0;
    X = '0; Y = '0; Rin = '0; Gin = '0; Bin = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(cal_done), 0);
    chk("rst_err", int'(cal_err), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_ref_r", int'(ref_r), 0);
    chk("rst_ref_g", int'(ref_g), 0);
    chk("rst_ref_b", int'(ref_b), 0);
    Reset_N = 1'b1;
    check_en = 1'b1;
    idle(3);

    // Constant colour.
    done_cnt = 0;
    req_pulse();
    chk("t1_busy_armed", int'(busy), 1);
    frame(0, 256);
    idle(5);
    chk("t1_ref_r", int'(ref_r), 300);
    chk("t1_ref_g", int'(ref_g), 500);
    chk("t1_ref_b", int'(ref_b), 100);
    chk("t1_run", int'(run), 1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_done_pulses", done_cnt, 1);

    // Ramp inside window, saturated values outside.
    done_cnt = 0;
    req_pulse();
    frame(1, 256);
    idle(5);
    chk("t2_ref_r", int'(ref_r), 30);
    chk("t2_ref_g", int'(ref_g), 0);
    chk("t2_ref_b", int'(ref_b), 0);
    chk("t2_done_pulses", done_cnt, 1);

    // Short frame: 200 window pixels then a new frame start.
    done_cnt = 0;
    req_pulse();
    frame(2, 200);
    chk("t3_busy_mid", int'(busy), 1);
    chk("t3_run_mid", int'(run), 0);
    vs_pulse();
    idle(5);
    chk("t3_err", int'(cal_err), 1);
    chk("t3_ref_r", int'(ref_r), 30);
    chk("t3_ref_g", int'(ref_g), 0);
    chk("t3_run", int'(run), 1);
    chk("t3_done_pulses", done_cnt, 0);

    // 256th pixel on the same edge as a frame start.
    done_cnt = 0;
    req_pulse();
    frame(2, 255);
    @(negedge CLK);
    X = 11'(CX); Y = 11'(CY); pixel_en = 1'b1;
    Rin = 10'($urandom); Gin = 10'($urandom); Bin = 10'($urandom);
    VGA_VS = 1'b0;
    @(negedge CLK);
    pixel_en = 1'b0;
    @(negedge CLK);
    VGA_VS = 1'b1;
    idle(5);
    chk("t4_err", int'(cal_err), 0);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_run", int'(run), 1);

    // Random calibrations.
    for (int i = 0; i < 3; i++) begin
      req_pulse();
      frame(2, 256);
      idle($urandom_range(2, 6));
    end

    // Request held across calibrations, dropped while the third is pending.
    done_cnt = 0;
    @(negedge CLK);
    calib_req = 1'b1;
    frame(2, 256);
    frame(2, 256);
    @(negedge CLK);
    calib_req = 1'b0;
    frame(0, 256);
    idle(5);
    chk("t6_done_pulses", done_cnt, 3);
    chk("t6_ref_r", int'(ref_r), 300);
    chk("t6_busy", int'(busy), 0);

    // Asynchronous reset mid-accumulation, then a clean calibration.
    req_pulse();
    frame(2, 100);
    @(negedge CLK);
    #2 Reset_N = 1'b0;
    #1;
    chk("t7_busy", int'(busy), 0);
    chk("t7_run", int'(run), 0);
    chk("t7_err", int'(cal_err), 0);
    chk("t7_ref_r", int'(ref_r), 0);
    chk("t7_ref_g", int'(ref_g), 0);
    chk("t7_ref_b", int'(ref_b), 0);
    @(negedge CLK);
    Reset_N = 1'b1;
    done_cnt = 0;
    req_pulse();
    frame(0, 256);
    idle(5);
    chk("t7_ref_r_after", int'(ref_r), 300);
    chk("t7_ref_g_after", int'(ref_g), 500);
    chk("t7_ref_b_after", int'(ref_b), 100);
    chk("t7_done_pulses", done_cnt, 1);

    // Green spread 10..900 inside the window.
    req_pulse();
    frame(3, 256);
    idle(5);
`ifdef COLOR_CALIB_MINMAX_EN
    chk("t8_min_g", int'(min_g), 10);
    chk("t8_max_g", int'(max_g), 900);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
